axi_lite_native_slave: RTL and testbench
========================================

// Module: axi_lite_native_slave
// PURPOSE
// AXI4-Lite responder that bridges a host/PS AXI-Lite master onto the accelerator's native register bus.
// Accepts AW/W/B writes and AR/R reads and serialises them onto one native port (single-cycle write strobe; read request with variable-latency return).
// Issues OKAY/SLVERR responses. Sits in front of the config/status register file, facing the AXI-Lite master bridge.
// PARAMETERS
// ADDR_WIDTH  32     AXI and native address width (byte address)
// DATA_WIDTH  32     data width; DATA_WIDTH/8 strobe bits
// REG_SPAN    4096   decoded byte span; addr >= REG_SPAN -> SLVERR
// RD_TIMEOUT  255    max cycles waiting i_reg_rvalid before SLVERR (8-bit counter)
// PORTS
// i_sys_clk      in   1             clock
// i_reset_n      in   1             asynchronous, active-low reset
// s_axi_awaddr   in   ADDR_WIDTH    write address
// s_axi_awvalid  in   1             write address valid
// s_axi_awready  out  1             write address ready
// s_axi_wdata    in   DATA_WIDTH    write data
// s_axi_wstrb    in   DATA_WIDTH/8  byte strobes
// s_axi_wvalid   in   1             write data valid
// s_axi_wready   out  1             write data ready
// s_axi_bresp    out  2             write response (00 OKAY, 10 SLVERR)
// s_axi_bvalid   out  1             write response valid
// s_axi_bready   in   1             write response ready
// s_axi_araddr   in   ADDR_WIDTH    read address
// s_axi_arvalid  in   1             read address valid
// s_axi_arready  out  1             read address ready
// s_axi_rdata    out  DATA_WIDTH    read data
// s_axi_rresp    out  2             read response
// s_axi_rvalid   out  1             read data valid
// s_axi_rready   in   1             read data ready
// o_reg_wr_en    out  1             native write strobe, 1-cycle pulse
// o_reg_rd_en    out  1             native read request, 1-cycle pulse
// o_reg_addr     out  ADDR_WIDTH    native address, word-aligned (low log2(DATA_WIDTH/8) bits forced 0)
// o_reg_wdata    out  DATA_WIDTH    native write data, valid with o_reg_wr_en
// o_reg_wstrb    out  DATA_WIDTH/8  native byte enables, valid with o_reg_wr_en
// i_reg_rdata    in   DATA_WIDTH    native read data, valid with i_reg_rvalid
// i_reg_rvalid   in   1             native read return, 1-cycle pulse
// BEHAVIOUR
// - Reset: all outputs 0 (readies 0, valids 0, resp 00, rdata 0, reg_* 0); in-flight transactions dropped, no response issued.
// - Write FSM W_IDLE->W_EXEC->W_RESP->W_IDLE. In W_IDLE awready/wready=1 until own beat captured; AW and W independent, any order or same cycle; both held -> W_EXEC.
// - W_EXEC: on native grant, 1-cycle o_reg_wr_en, then W_RESP; bvalid held with bresp stable until bready. Min latency: AW+W at cycle 0 -> wr_en cycle 1 -> bvalid cycle 2.
// - Read FSM R_IDLE->R_ISSUE->R_WAIT->R_RESP->R_IDLE. arready=1 only in R_IDLE; on grant 1-cycle o_reg_rd_en; R_WAIT latches i_reg_rdata, rresp=00; rvalid the cycle after i_reg_rvalid, held until rready.
// - Timeout: R_WAIT counter reaching RD_TIMEOUT -> rdata=0, rresp=10; a later stray i_reg_rvalid ignored.
// - Arbiter: one native op per cycle; W_EXEC and R_ISSUE same cycle -> write first, read next cycle; write blocked while read in R_WAIT.
// - Decode: addr >= REG_SPAN -> no native access, SLVERR (read rdata=0), same latency; write with wstrb==0 -> no wr_en, bresp OKAY.
// - One outstanding write and one outstanding read max; no new AW/W/AR accepted until own response handshakes.
// STRUCTURE
// - Package axil_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write/read FSM state enums.
// - Single module; no sub-module (arbiter is one priority mux).
// TESTING
// - AW(0x10)+W(0xDEADBEEF,strb F) same cycle -> wr_en cycle 1 addr 0x10, bvalid cycle 2 bresp 00.
// - W 3 cycles before AW(0x24), bready low 4 cycles -> single wr_en; bvalid held, bresp stable until bready.
// - AR 0x08, i_reg_rvalid 5 cycles after rd_en with 0x1234 -> rvalid next cycle rdata 0x1234 rresp 00.
// - AR 0x2000 (>= REG_SPAN) -> no rd_en, rresp 10 rdata 0; AW 0x3000 -> no wr_en, bresp 10.
// - Native never returns -> rresp 10 after RD_TIMEOUT cycles; late i_reg_rvalid does not create second rvalid.
// - AW/W and AR same cycle -> wr_en before rd_en, both respond OKAY; reset asserted mid R_WAIT -> all outputs 0.

Source files
------------

// File: rtl/axi_lite_native_slave_pkg.sv
// Shared response codes and FSM state encodings for the AXI-Lite to
// native register bus bridge.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_EXEC,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/axi_lite_native_slave.sv
// AXI4-Lite responder: one outstanding write and one outstanding read,
// serialised onto a single native register port with write priority.
module axi_lite_native_slave
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_SPAN   = 4096,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    i_sys_clk,
  input  logic                    i_reset_n,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    o_reg_wr_en,
  output logic                    o_reg_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_reg_addr,
  output logic [DATA_WIDTH-1:0]   o_reg_wdata,
  output logic [DATA_WIDTH/8-1:0] o_reg_wstrb,
  input  logic [DATA_WIDTH-1:0]   i_reg_rdata,
  input  logic                    i_reg_rvalid
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(STRB_W - 1));
  localparam logic [ADDR_WIDTH-1:0] SPAN       = ADDR_WIDTH'(REG_SPAN);
  localparam logic [7:0]            TMO_LAST   = 8'(RD_TIMEOUT - 1);

  // Write channel state
  w_state_t              w_state_q, w_state_d;
  logic                  aw_have_q, aw_have_d;
  logic                  w_have_q, w_have_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;

  // Read channel state
  r_state_t              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [7:0]            tmo_q, tmo_d;

  // Holds readies low while reset is asserted and for the first edge after it.
  logic                  live_q;

  logic w_in_range, w_access, r_in_range;
  logic grant_w, grant_r;
  logic aw_hs, w_hs, ar_hs;

  assign w_in_range = (awaddr_q < SPAN);
  assign w_access   = w_in_range && (|wstrb_q);
  assign r_in_range = (araddr_q < SPAN);

  // Priority arbiter: a pending write wins, but never while a read is in flight.
  assign grant_w = (w_state_q == W_EXEC) && w_access && (r_state_q != R_WAIT);
  assign grant_r = (r_state_q == R_ISSUE) && r_in_range && !grant_w;

  assign s_axi_awready = live_q && (w_state_q == W_IDLE) && !aw_have_q;
  assign s_axi_wready  = live_q && (w_state_q == W_IDLE) && !w_have_q;
  assign s_axi_arready = live_q && (r_state_q == R_IDLE);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (r_state_q == R_RESP);
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign o_reg_wr_en = grant_w;
  assign o_reg_rd_en = grant_r;
  assign o_reg_addr  = grant_w ? (awaddr_q & ALIGN_MASK) :
                       grant_r ? (araddr_q & ALIGN_MASK) : '0;
  assign o_reg_wdata = grant_w ? wdata_q : '0;
  assign o_reg_wstrb = grant_w ? wstrb_q : '0;

  always_comb begin
    w_state_d = w_state_q;
    aw_have_d = aw_have_q;
    w_have_d  = w_have_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_have_d = 1'b1;
          awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
          w_have_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_have_d && w_have_d) begin
          w_state_d = W_EXEC;
        end
      end
      W_EXEC: begin
        // Decode errors and empty strobes skip the native port but keep the latency.
        if (!w_access) begin
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end else if (grant_w) begin
          bresp_d   = RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
          aw_have_d = 1'b0;
          w_have_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    tmo_d     = tmo_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          araddr_d  = s_axi_araddr;
          r_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (!r_in_range) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else if (grant_r) begin
          tmo_d     = '0;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (i_reg_rvalid) begin
          rdata_d   = i_reg_rdata;
          rresp_d   = RESP_OKAY;
          r_state_d = R_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d   = '0;
          rresp_d   = RESP_SLVERR;
          r_state_d = R_RESP;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      aw_have_q <= 1'b0;
      w_have_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      tmo_q     <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      aw_have_q <= aw_have_d;
      w_have_q  <= w_have_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      tmo_q     <= tmo_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_native_slave.sv
// Directed bench for axi_lite_native_slave: a vector table of single
// transactions plus hand-written multi-cycle sequences.
module tb_axi_lite_native_slave;

  localparam int RD_TIMEOUT = 255;

  logic        clk;
  logic        i_reset_n;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        o_reg_wr_en;
  logic        o_reg_rd_en;
  logic [31:0] o_reg_addr;
  logic [31:0] o_reg_wdata;
  logic [3:0]  o_reg_wstrb;
  logic [31:0] i_reg_rdata;
  logic        i_reg_rvalid;

  axi_lite_native_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REG_SPAN(4096), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .i_sys_clk(clk), .i_reset_n(i_reset_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .o_reg_wr_en(o_reg_wr_en), .o_reg_rd_en(o_reg_rd_en), .o_reg_addr(o_reg_addr),
    .o_reg_wdata(o_reg_wdata), .o_reg_wstrb(o_reg_wstrb),
    .i_reg_rdata(i_reg_rdata), .i_reg_rvalid(i_reg_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Native-side monitor, sampled on the falling edge.
  int          cyc = 0;
  int          wr_cnt = 0, rd_cnt = 0, wr_cyc = -1, rd_cyc = -1;
  logic [31:0] wr_addr, wr_data, rd_addr;
  logic [3:0]  wr_strb;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (o_reg_wr_en) begin
      wr_cnt = wr_cnt + 1; wr_cyc = cyc;
      wr_addr = o_reg_addr; wr_data = o_reg_wdata; wr_strb = o_reg_wstrb;
    end
    if (o_reg_rd_en) begin
      rd_cnt = rd_cnt + 1; rd_cyc = cyc; rd_addr = o_reg_addr;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
            s_axi_rvalid, s_axi_rresp, o_reg_wr_en, o_reg_rd_en, 1'b0,
            (|s_axi_rdata), (|o_reg_addr), (|o_reg_wdata), (|o_reg_wstrb)};
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat, output int nwr);
    int t0, n0;
    bit seen;
    n0 = wr_cnt; t0 = cyc; seen = 0; resp = 2'b11; lat = -1;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (s_axi_bvalid) begin
        seen = 1; resp = s_axi_bresp; lat = cyc - t0;
        break;
      end
      step();
    end
    chk("wr_bvalid_seen", 64'(seen), 64'd1);
    step();
    s_axi_bready = 1'b0;
    nwr = wr_cnt - n0;
  endtask

  // dly > 0: native returns ret dly cycles after rd_en; dly <= 0: never returns.
  task automatic do_read(input logic [31:0] addr, input int dly, input logic [31:0] ret,
                         output logic [31:0] rdata, output logic [1:0] resp,
                         output int lat, output int nrd);
    int t0, n0, rc;
    bit seen;
    n0 = rd_cnt; t0 = cyc; seen = 0; rc = -1; resp = 2'b11; rdata = '1; lat = -1;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (rc < 0 && rd_cnt != n0) rc = rd_cyc;
      if (s_axi_rvalid) begin
        seen = 1; resp = s_axi_rresp; rdata = s_axi_rdata; lat = cyc - t0;
        break;
      end
      i_reg_rvalid = (dly > 0 && rc >= 0 && cyc == rc + dly);
      i_reg_rdata  = i_reg_rvalid ? ret : 32'hBAD0_BAD0;
      step();
    end
    i_reg_rvalid = 1'b0;
    chk("rd_rvalid_seen", 64'(seen), 64'd1);
    step();
    s_axi_rready = 1'b0;
    nrd = rd_cnt - n0;
  endtask

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    int          exp_n;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [31:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat, n, t, n0, r0, k;
    bit          ok, bseen, rseen;
    logic [1:0]  bresp_c, rresp_c;
    logic [31:0] rdata_c;

    // write lat = AW cycle to bvalid; read lat = AR cycle to rvalid (dly+2 when native returns)
    vecs[0] = '{0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 2'b00, 32'h0, 32'h0000_0010, 2};
    vecs[1] = '{1, 32'h0000_0008, 32'h0,         4'h0, 5, 1, 2'b00, 32'h0000_1234, 32'h0000_0008, 7};
    vecs[2] = '{1, 32'h0000_2000, 32'h0,         4'h0, 3, 0, 2'b10, 32'h0, 32'h0, 2};
    vecs[3] = '{0, 32'h0000_3000, 32'h1111_1111, 4'hF, 0, 0, 2'b10, 32'h0, 32'h0, 2};
    vecs[4] = '{0, 32'h0000_0FFD, 32'h00AB_0000, 4'h4, 0, 1, 2'b00, 32'h0, 32'h0000_0FFC, 2};
    vecs[5] = '{0, 32'h0000_0FFC, 32'h5555_5555, 4'h0, 0, 0, 2'b00, 32'h0, 32'h0, 2};
    vecs[6] = '{0, 32'h0000_1000, 32'h7777_7777, 4'hF, 0, 0, 2'b10, 32'h0, 32'h0, 2};
    vecs[7] = '{1, 32'h0000_0FFC, 32'h0,         4'h0, 1, 1, 2'b00, 32'hA5A5_A5A5, 32'h0000_0FFC, 3};
    vecs[8] = '{1, 32'h0000_1000, 32'h0,         4'h0, 2, 0, 2'b10, 32'h0, 32'h0, 2};
    vecs[9] = '{1, 32'h0000_0003, 32'h0,         4'h0, 2, 1, 2'b00, 32'h55AA_0001, 32'h0000_0000, 4};

    i_reset_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; i_reg_rdata = '0; i_reg_rvalid = 1'b0;

    repeat (3) step();
    chk("reset_outputs", all_outputs(), 64'd0);
    i_reset_n = 1'b1;
    step(); step();
    chk("post_reset_ready", {62'd0, s_axi_awready, s_axi_arready}, 64'd3);
    $display("reset released, readies up");

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_rd) begin
        do_read(vecs[i].addr, vecs[i].dly, vecs[i].exp_rdata, rdata, resp, lat, n);
        chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
        if (vecs[i].exp_n == 1) chk($sformatf("v%0d_rd_addr", i), 64'(rd_addr), 64'(vecs[i].exp_addr));
      end else begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat, n);
        if (vecs[i].exp_n == 1) begin
          chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].exp_addr));
          chk($sformatf("v%0d_wr_data", i), 64'(wr_data), 64'(vecs[i].data));
          chk($sformatf("v%0d_wr_strb", i), 64'(wr_strb), 64'(vecs[i].strb));
        end
      end
      chk($sformatf("v%0d_resp", i), 64'(resp), 64'(vecs[i].exp_resp));
      chk($sformatf("v%0d_native_ops", i), 64'(n), 64'(vecs[i].exp_n));
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      $display("vec %0d %s addr=%08h resp=%0d rdata=%08h lat=%0d native_ops=%0d",
               i, vecs[i].is_rd ? "RD" : "WR", vecs[i].addr, resp, rdata, lat, n);
    end

    // W three cycles ahead of AW, bready held low four cycles.
    n0 = wr_cnt; t = cyc;
    s_axi_wdata = 32'hCAFE_F00D; s_axi_wstrb = 4'h3; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    chk("w_first_wready_low", 64'(s_axi_wready), 64'd0);
    chk("w_first_awready", 64'(s_axi_awready), 64'd1);
    step(); step();
    s_axi_awaddr = 32'h0000_0024; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    chk("w_first_wr_cyc", 64'(wr_cyc - t), 64'd4);
    chk("w_first_addr", 64'(wr_addr), 64'h24);
    chk("w_first_data", 64'(wr_data), 64'hCAFE_F00D);
    chk("w_first_strb", 64'(wr_strb), 64'h3);
    step();
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (!(s_axi_bvalid === 1'b1 && s_axi_bresp === 2'b00)) ok = 0;
      step();
    end
    chk("bvalid_held", 64'(ok), 64'd1);
    chk("bvalid_before_bready", 64'(s_axi_bvalid), 64'd1);
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    chk("bvalid_after_bready", 64'(s_axi_bvalid), 64'd0);
    chk("w_first_single_wr", 64'(wr_cnt - n0), 64'd1);
    $display("seq W-before-AW wr_ops=%0d addr=%08h", wr_cnt - n0, wr_addr);

    // Native never answers: SLVERR after the timeout, stray return ignored.
    do_read(32'h0000_0040, 0, 32'h0, rdata, resp, lat, n);
    chk("tmo_resp", 64'(resp), 64'd2);
    chk("tmo_rdata", 64'(rdata), 64'd0);
    chk("tmo_rd_ops", 64'(n), 64'd1);
    chk("tmo_latency_window", 64'(lat >= RD_TIMEOUT + 1 && lat <= RD_TIMEOUT + 3), 64'd1);
    $display("seq timeout resp=%0d lat=%0d", resp, lat);
    i_reg_rvalid = 1'b1; i_reg_rdata = 32'hFFFF_FFFF;
    step();
    i_reg_rvalid = 1'b0;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (s_axi_rvalid !== 1'b0) ok = 0;
      step();
    end
    chk("stray_no_rvalid", 64'(ok), 64'd1);
    do_read(32'h0000_0044, 3, 32'h0000_600D, rdata, resp, lat, n);
    chk("post_tmo_rdata", 64'(rdata), 64'h600D);
    chk("post_tmo_resp", 64'(resp), 64'd0);
    $display("seq post-timeout read rdata=%08h resp=%0d", rdata, resp);

    // Write and read presented together: write reaches the native port first.
    n0 = wr_cnt; r0 = rd_cnt; k = cyc; bseen = 0; rseen = 0;
    bresp_c = 2'b11; rresp_c = 2'b11; rdata_c = '1;
    s_axi_awaddr = 32'h50; s_axi_wdata = 32'h0F0F_0F0F; s_axi_wstrb = 4'hF; s_axi_araddr = 32'h54;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    step();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (s_axi_bvalid && !bseen) begin bseen = 1; bresp_c = s_axi_bresp; end
      if (s_axi_rvalid && !rseen) begin rseen = 1; rresp_c = s_axi_rresp; rdata_c = s_axi_rdata; end
      if (bseen && rseen) break;
      i_reg_rvalid = (rd_cnt != r0) && (cyc == rd_cyc + 2);
      i_reg_rdata  = i_reg_rvalid ? 32'h77 : 32'h0;
      step();
    end
    i_reg_rvalid = 1'b0;
    step();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    chk("both_seen", {62'd0, bseen, rseen}, 64'd3);
    chk("arb_wr_cyc", 64'(wr_cyc - k), 64'd1);
    chk("arb_rd_cyc", 64'(rd_cyc - k), 64'd2);
    chk("arb_rd_addr", 64'(rd_addr), 64'h54);
    chk("arb_bresp", 64'(bresp_c), 64'd0);
    chk("arb_rresp", 64'(rresp_c), 64'd0);
    chk("arb_rdata", 64'(rdata_c), 64'h77);
    $display("seq arbitration wr@+%0d rd@+%0d rdata=%08h", wr_cyc - k, rd_cyc - k, rdata_c);

    // Reset while the read waits on the native port.
    r0 = rd_cnt;
    s_axi_araddr = 32'h0C; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    step();
    s_axi_arvalid = 1'b0;
    step(); step(); step();
    chk("rst_mid_rd_issued", 64'(rd_cnt - r0), 64'd1);
    i_reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", all_outputs(), 64'd0);
    step();
    chk("rst_mid_outputs_held", all_outputs(), 64'd0);
    i_reset_n = 1'b1;
    step(); step();
    chk("rst_mid_recover", {62'd0, s_axi_arready, s_axi_rvalid}, 64'd2);
    s_axi_rready = 1'b0;
    $display("seq reset mid-read outputs cleared");

    do_write(32'h0000_0010, 32'h1234_5678, 4'hF, resp, lat, n);
    chk("post_rst_wr_resp", 64'(resp), 64'd0);
    chk("post_rst_wr_ops", 64'(n), 64'd1);
    $display("seq post-reset write resp=%0d lat=%0d", resp, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
